// File: rtl/pipe_register.sv
// rtl/pipe_register.sv - multi-stage valid/ready pipeline register with occupancy tracking
// Each stage advances when any downstream stage is empty or the output is accepted.
module pipe_register #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         clear_i,
  input  logic                         in_valid_i,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         in_ready_o,
  output logic                         out_valid_o,
  output logic [WIDTH-1:0]             out_data_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_src_vld;
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;

  // rdy[k] = ~vld[k] | rdy[k+1] unrolled into "any hole from k onward, or
  // output accepted" so no bit of w_rdy depends on another bit of itself.
  assign w_rdy[DEPTH] = out_ready_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign w_rdy[k] = out_ready_i | ~(&r_vld[DEPTH-1:k]);

    if (k == 0) begin : g_head
      assign w_src_vld[k]  = in_valid_i;
      assign w_src_data[k] = in_data_i;
    end else begin : g_body
      assign w_src_vld[k]  = r_vld[k-1];
      assign w_src_data[k] = r_data[k-1];
    end
  end

  assign in_ready_o  = w_rdy[0] & ~clear_i;
  assign out_valid_o = r_vld[DEPTH-1];
  assign out_data_o  = r_data[DEPTH-1];

  assign w_in_xfer  = in_valid_i & in_ready_o;
  assign w_out_xfer = out_valid_o & out_ready_i;

  // A bubble moving into a stage clears its valid but leaves the data alone.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      r_vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= w_src_vld[k];
          if (w_src_vld[k]) begin
            r_data[k] <= w_src_data[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      r_occ <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occupancy_o = r_occ;
  assign empty_o     = (r_occ == '0);
  assign full_o      = (r_occ == OCC_W'(DEPTH));

endmodule

// File: doc/pipe_register.md
PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every stage data register on reset or clear.
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port clear_i, input, 1 bit: synchronous flush of all stages.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: input beat present.
REQ-008 The block SHALL have port in_data_i, input, WIDTH bits: input beat data.
REQ-009 The block SHALL have port in_ready_o, output, 1 bit: block accepts the input beat this cycle.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit: last stage holds a beat.
REQ-011 The block SHALL have port out_data_o, output, WIDTH bits: last-stage data.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts a beat.
REQ-013 The block SHALL have port occupancy_o, output, $clog2(DEPTH+1) bits: number of valid stages.
REQ-014 The block SHALL have ports empty_o and full_o, outputs, 1 bit each: occupancy_o==0 and occupancy_o==DEPTH respectively.

Function
REQ-015 Each stage k (0..DEPTH-1) SHALL hold a data register and a valid bit; stage 0 is fed from the input, stage DEPTH-1 drives out_data_o/out_valid_o.
REQ-016 Per-stage ready SHALL be combinational: rdy[DEPTH]=out_ready_i; rdy[k]=~vld[k] | rdy[k+1]; in_ready_o=rdy[0] & ~clear_i.
REQ-017 A transfer SHALL occur on a port only when valid and ready are both 1 on the same rising edge.
REQ-018 When rdy[k]=1, stage k SHALL load from stage k-1 (or from the input for k=0): vld[k]<=vld[k-1] (in_valid_i for k=0) and data[k]<=data[k-1] (in_data_i).
REQ-019 When rdy[k]=0, stage k SHALL hold both data and valid unchanged.
REQ-020 Data registers SHALL load only when the incoming valid is 1; a bubble moving in SHALL clear vld[k] without changing data[k].
REQ-021 Latency from input acceptance to out_valid_o=1 SHALL be exactly DEPTH cycles with out_ready_i held 1.
REQ-022 Throughput SHALL be one beat per cycle with no bubbles while out_ready_i=1; a full pipeline SHALL accept a new beat in the same cycle the output transfers.
REQ-023 occupancy_o SHALL be a registered count: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither; it SHALL never exceed DEPTH nor underflow.
REQ-024 When clear_i=1 on an edge, all vld[k] SHALL become 0, all data SHALL become RESET_VAL and occupancy_o SHALL become 0; no input transfer counts that cycle (in_ready_o=0), and any output transfer that cycle is the last from the flushed contents.
REQ-025 Beat order SHALL be preserved; no beat SHALL be duplicated or dropped except by clear or reset.
REQ-026 out_data_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-027 When rst_n_i=0 on a rising edge, all vld[k]=0, all data=RESET_VAL and occupancy_o=0 SHALL result; reset has priority over clear_i and all transfers.
REQ-028 After reset, out_valid_o=0, out_data_o=RESET_VAL, empty_o=1, full_o=0 and in_ready_o=1 (when clear_i=0) SHALL hold.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight beats; the first beat accepted after release SHALL be the first beat output.

Verification (WIDTH=8, DEPTH=3, RESET_VAL=0)
REQ-030 Streaming: inputs 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready_i=1 -> outputs appear in order starting 3 cycles after the first acceptance, one per cycle, occupancy_o steady at 3.
REQ-031 Backpressure: out_ready_i=0 while 5 beats are offered -> exactly 3 accepted, full_o=1, in_ready_o=0, out_data_o stable at first beat; raise out_ready_i -> remaining beats drain in order with no loss.
REQ-032 Simultaneous: full pipeline, out_ready_i=1 and in_valid_i=1 -> in_ready_o=1, occupancy_o stays 3.
REQ-033 Bubbles: alternate in_valid_i 1/0 with 0xA5,0x5A -> out_valid_o toggles correspondingly, occupancy_o oscillates 1..2, no spurious beats.
REQ-034 Clear: pipeline holding 2 beats, clear_i=1 with in_valid_i=1 -> next cycle occupancy_o=0, empty_o=1, out_data_o=0x00, offered beat not accepted.
REQ-035 Reset mid-stream: rst_n_i=0 for one edge with 3 beats in flight -> all outputs at reset values; next beat 0x7E emerges alone after 3 cycles.
